// File: rtl/dk_downlink_capture_if.sv
`default_nettype none
// ============================================================================
// Module   : dk_downlink_capture_if
// Brief    : Frame stream from the downlink capture FIFO to the telemetry path.
// Revision : 1.0
// ============================================================================
interface dk_downlink_capture_if #(
    parameter int BITS = 40
);
    logic [BITS-1:0] frame_data;
    logic            frame_valid;
    logic            frame_ready;
    logic [1:0]      frame_perr;

    modport master (
        output frame_data,
        output frame_valid,
        output frame_perr,
        input  frame_ready
    );

    modport slave (
        input  frame_data,
        input  frame_valid,
        input  frame_perr,
        output frame_ready
    );
endinterface
`default_nettype wire

// File: rtl/dk_downlink_capture.sv
`default_nettype none
// ============================================================================
// Module   : dk_downlink_capture
// Brief    : Captures AGC downlink frames (DKSTRT..DKEND) into a small FIFO.
//            Optional macro DK_PARITY_CHECK_EN adds per-word odd-parity flags.
// Revision : 1.0
// ============================================================================
module dk_downlink_capture #(
    parameter int BITS  = 40,
    parameter int DEPTH = 4
) (
    input  wire logic                     clk,
    input  wire logic                     rst_n,
    input  wire logic                     dkstrt,
    input  wire logic                     dkbsnc,
    input  wire logic                     dkend,
    input  wire logic                     dkdata,
    dk_downlink_capture_if.master         frm,
    output logic [$clog2(DEPTH):0]        fifo_level,
    output logic                          busy,
    output logic [7:0]                    drop_count,
    output logic [7:0]                    err_count
);
    localparam int c_AW = $clog2(DEPTH);
    localparam int c_CW = $clog2(BITS + 1);
    localparam logic [c_AW:0]   c_FULL = DEPTH[c_AW:0];
    localparam logic [c_CW-1:0] c_BITS = BITS[c_CW-1:0];

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_OVER  = 2'd2
    } state_t;

    logic [1:0] r_strt_sy, r_bsnc_sy, r_end_sy, r_data_sy;
    logic       r_strt_d, r_bsnc_d, r_end_d;
    logic       r_strt_ev, r_end_ev, r_bit_ev, r_bit_smp;

    // Edge pulses are registered, so an event acts 3 cycles after the input pin.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_strt_sy <= '0;
            r_bsnc_sy <= '0;
            r_end_sy  <= '0;
            r_data_sy <= '0;
            r_strt_d  <= 1'b0;
            r_bsnc_d  <= 1'b0;
            r_end_d   <= 1'b0;
            r_strt_ev <= 1'b0;
            r_end_ev  <= 1'b0;
            r_bit_ev  <= 1'b0;
            r_bit_smp <= 1'b0;
        end else begin
            r_strt_sy <= {r_strt_sy[0], dkstrt};
            r_bsnc_sy <= {r_bsnc_sy[0], dkbsnc};
            r_end_sy  <= {r_end_sy[0],  dkend};
            r_data_sy <= {r_data_sy[0], dkdata};
            r_strt_d  <= r_strt_sy[1];
            r_bsnc_d  <= r_bsnc_sy[1];
            r_end_d   <= r_end_sy[1];
            r_strt_ev <= r_strt_sy[1] & ~r_strt_d;
            r_end_ev  <= r_end_sy[1]  & ~r_end_d;
            r_bit_ev  <= ~r_bsnc_sy[1] & r_bsnc_d;
            r_bit_smp <= r_data_sy[1];
        end
    end

    state_t            r_state, w_state_nxt;
    logic [BITS-1:0]   r_shift;
    logic [c_CW-1:0]   r_cnt;
    logic              w_clear, w_shift, w_push, w_err_inc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    // Event priority within a cycle: start, then end, then bit.
    always_comb begin
        w_state_nxt = r_state;
        w_clear     = 1'b0;
        w_shift     = 1'b0;
        w_push      = 1'b0;
        w_err_inc   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (r_strt_ev) begin
                    w_state_nxt = S_SHIFT;
                    w_clear     = 1'b1;
                end
            end
            S_SHIFT: begin
                if (r_strt_ev) begin
                    w_err_inc = 1'b1;
                    w_clear   = 1'b1;
                end else if (r_end_ev) begin
                    w_state_nxt = S_IDLE;
                    if (r_cnt == c_BITS) w_push    = 1'b1;
                    else                 w_err_inc = 1'b1;
                end else if (r_bit_ev) begin
                    if (r_cnt == c_BITS) w_state_nxt = S_OVER;
                    else                 w_shift     = 1'b1;
                end
            end
            S_OVER: begin
                if (r_strt_ev) begin
                    w_err_inc   = 1'b1;
                    w_clear     = 1'b1;
                    w_state_nxt = S_SHIFT;
                end else if (r_end_ev) begin
                    w_err_inc   = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shift <= '0;
            r_cnt   <= '0;
        end else if (w_clear) begin
            r_shift <= '0;
            r_cnt   <= '0;
        end else if (w_shift) begin
            r_shift <= {r_shift[BITS-2:0], r_bit_smp};
            r_cnt   <= r_cnt + 1'b1;
        end
    end

    logic [BITS-1:0]  r_mem [DEPTH];
    logic [c_AW-1:0]  r_wr_ptr, r_rd_ptr;
    logic [c_AW:0]    r_level;
    logic [7:0]       r_drop, r_err;
    logic             w_full, w_pop, w_wr, w_drop, w_valid;

    assign w_valid = (r_level != '0);
    assign w_full  = (r_level == c_FULL);
    assign w_pop   = w_valid & frm.frame_ready;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign w_wr    = w_push & (~w_full | w_pop);
    assign w_drop  = w_push & w_full & ~w_pop;

    always_ff @(posedge clk) begin
        if (w_wr) r_mem[r_wr_ptr] <= r_shift;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
            r_drop   <= '0;
            r_err    <= '0;
        end else begin
            if (w_wr)  r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
            if (w_wr && !w_pop)      r_level <= r_level + 1'b1;
            else if (!w_wr && w_pop) r_level <= r_level - 1'b1;
            if (w_drop && r_drop != 8'hFF)   r_drop <= r_drop + 1'b1;
            if (w_err_inc && r_err != 8'hFF) r_err  <= r_err + 1'b1;
        end
    end

`ifdef DK_PARITY_CHECK_EN
    // Only meaningful for 40-bit frames: words are [39:24] and [23:8].
    logic [1:0] r_perr_mem [DEPTH];
    logic [1:0] w_perr_in;

    assign w_perr_in = {~^r_shift[39:24], ~^r_shift[23:8]};

    always_ff @(posedge clk) begin
        if (w_wr) r_perr_mem[r_wr_ptr] <= w_perr_in;
    end

    assign frm.frame_perr = w_valid ? r_perr_mem[r_rd_ptr] : 2'b00;
`else
    assign frm.frame_perr = 2'b00;
`endif

    assign frm.frame_valid = w_valid;
    assign frm.frame_data  = w_valid ? r_mem[r_rd_ptr] : '0;
    assign fifo_level      = r_level;
    assign busy            = (r_state != S_IDLE);
    assign drop_count      = r_drop;
    assign err_count       = r_err;

endmodule
`default_nettype wire

// File: tb/tb_dk_downlink_capture.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_dk_downlink_capture
// Brief    : Self-checking bench for dk_downlink_capture with a frame-level model.
// Revision : 1.0
// ============================================================================
module tb_dk_downlink_capture;
    localparam int BITS  = 40;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic dkstrt = 1'b0, dkbsnc = 1'b0, dkend = 1'b0, dkdata = 1'b0;
    logic [$clog2(DEPTH):0] fifo_level;
    logic busy;
    logic [7:0] drop_count, err_count;

    dk_downlink_capture_if #(.BITS(BITS)) u_if ();

    dk_downlink_capture #(.BITS(BITS), .DEPTH(DEPTH)) u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .dkstrt     (dkstrt),
        .dkbsnc     (dkbsnc),
        .dkend      (dkend),
        .dkdata     (dkdata),
        .frm        (u_if.master),
        .fifo_level (fifo_level),
        .busy       (busy),
        .drop_count (drop_count),
        .err_count  (err_count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Model: list of accepted frames plus the two counters.
    logic [BITS-1:0] m_q [$];
    int m_err = 0;
    int m_drop = 0;
    logic [BITS-1:0] got_q [$];
    logic [1:0]      got_perr_q [$];

    function automatic logic [1:0] exp_perr(logic [39:0] f);
`ifdef DK_PARITY_CHECK_EN
        return {($countones(f[39:24]) % 2 == 0), ($countones(f[23:8]) % 2 == 0)};
`else
        return 2'b00;
`endif
    endfunction

    task automatic hold(int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic strobe_strt();
        dkstrt = 1'b1; hold($urandom_range(3, 5));
        dkstrt = 1'b0; hold($urandom_range(3, 5));
    endtask

    task automatic strobe_end();
        dkend = 1'b1; hold($urandom_range(3, 5));
        dkend = 1'b0; hold($urandom_range(3, 5));
    endtask

    task automatic send_bits(logic [63:0] d, int n);
        for (int i = 0; i < n; i++) begin
            dkdata = d[n-1-i];
            hold(1);
            dkbsnc = 1'b1; hold($urandom_range(3, 5));
            dkbsnc = 1'b0; hold($urandom_range(3, 5));
        end
    endtask

    task automatic model_frame(logic [63:0] d, int n);
        if (n == BITS) begin
            if (m_q.size() == DEPTH) begin
                if (m_drop < 255) m_drop++;
            end else begin
                m_q.push_back(d[BITS-1:0]);
            end
        end else if (m_err < 255) begin
            m_err++;
        end
    endtask

    task automatic send_frame(logic [63:0] d, int n);
        strobe_strt();
        send_bits(d, n);
        strobe_end();
        hold(2);
        model_frame(d, n);
    endtask

    task automatic drain();
        got_q.delete();
        got_perr_q.delete();
        u_if.frame_ready = 1'b1;
        for (int c = 0; c < 4 * DEPTH; c++) begin
            if (!u_if.frame_valid) break;
            got_q.push_back(u_if.frame_data);
            got_perr_q.push_back(u_if.frame_perr);
            @(negedge clk);
        end
        u_if.frame_ready = 1'b0;
        hold(1);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        u_if.frame_ready = 1'b0;
        hold(4);
        n_checks++;
        if (u_if.frame_valid !== 1'b0 || fifo_level !== '0 || busy !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_ctrl: valid=%b level=%0d busy=%b, required 0/0/0",
                     u_if.frame_valid, fifo_level, busy);
        end
        n_checks++;
        if (err_count !== 8'd0 || drop_count !== 8'd0 || u_if.frame_data !== '0 ||
            u_if.frame_perr !== 2'b00) begin
            n_errors++;
            $display("FAIL reset_data: err=%0d drop=%0d data=%h perr=%b, required zeros",
                     err_count, drop_count, u_if.frame_data, u_if.frame_perr);
        end
        rst_n = 1'b1;
        hold(3);
    endtask

    task automatic test_nominal();
        logic [63:0] d = 64'hA5A5F00F3C;
        logic [4:1] v, b;
        strobe_strt();
        send_bits(d, BITS);
        dkend = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            @(posedge clk); #1;
            v[k] = u_if.frame_valid;
            b[k] = busy;
        end
        hold(3);
        dkend = 1'b0;
        hold(4);
        model_frame(d, BITS);
        n_checks++;
        if (v[3] !== 1'b0 || v[4] !== 1'b1) begin
            n_errors++;
            $display("FAIL nominal_latency: valid after clk1..4=%b, required 1000 (msb=clk4)", v);
        end
        n_checks++;
        if (b[3] !== 1'b1 || b[4] !== 1'b0) begin
            n_errors++;
            $display("FAIL nominal_busy: busy after clk1..4=%b, required 0111 (msb=clk4)", b);
        end
        n_checks++;
        if (err_count !== 8'(m_err)) begin
            n_errors++;
            $display("FAIL nominal_err: got %0d required %0d", err_count, m_err);
        end
        drain();
        n_checks++;
        if (got_q.size() != 1 || got_q[0] !== 40'hA5A5F00F3C) begin
            n_errors++;
            $display("FAIL nominal_data: got %0d frames head=%h required 1 frame a5a5f00f3c",
                     got_q.size(), (got_q.size() > 0) ? got_q[0] : '0);
        end
        m_q.delete();
    endtask

    task automatic test_short();
        send_frame({$urandom, $urandom}, BITS - 1);
        n_checks++;
        if (err_count !== 8'(m_err) || u_if.frame_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL short_frame: err=%0d valid=%b required err=%0d valid=0",
                     err_count, u_if.frame_valid, m_err);
        end
    endtask

    task automatic test_long();
        logic [63:0] d = {$urandom, $urandom};
        strobe_strt();
        send_bits(d, 45);
        n_checks++;
        if (busy !== 1'b1 || err_count !== 8'(m_err)) begin
            n_errors++;
            $display("FAIL long_over: busy=%b err=%0d required busy=1 err=%0d", busy, err_count, m_err);
        end
        strobe_end();
        hold(2);
        model_frame(d, 45);
        n_checks++;
        if (err_count !== 8'(m_err) || fifo_level !== '0 || busy !== 1'b0) begin
            n_errors++;
            $display("FAIL long_frame: err=%0d level=%0d busy=%b required err=%0d level=0 busy=0",
                     err_count, fifo_level, busy, m_err);
        end
    endtask

    task automatic test_backpressure();
        for (int f = 0; f < 6; f++) send_frame({$urandom, $urandom}, BITS);
        n_checks++;
        if (fifo_level !== ($clog2(DEPTH)+1)'(m_q.size()) || drop_count !== 8'(m_drop)) begin
            n_errors++;
            $display("FAIL bp_full: level=%0d drop=%0d required level=%0d drop=%0d",
                     fifo_level, drop_count, m_q.size(), m_drop);
        end
        drain();
        n_checks++;
        if (got_q.size() != m_q.size() || fifo_level !== '0) begin
            n_errors++;
            $display("FAIL bp_drain_count: popped=%0d level=%0d required popped=%0d level=0",
                     got_q.size(), fifo_level, m_q.size());
        end
        for (int i = 0; i < m_q.size() && i < got_q.size(); i++) begin
            n_checks++;
            if (got_q[i] !== m_q[i] || got_perr_q[i] !== exp_perr(m_q[i])) begin
                n_errors++;
                $display("FAIL bp_order[%0d]: got %h/%b required %h/%b",
                         i, got_q[i], got_perr_q[i], m_q[i], exp_perr(m_q[i]));
            end
        end
        m_q.delete();
    endtask

    task automatic test_restart();
        strobe_strt();
        send_bits({$urandom, $urandom}, 20);
        if (m_err < 255) m_err++;
        send_frame({$urandom, $urandom}, BITS);
        n_checks++;
        if (err_count !== 8'(m_err) || fifo_level !== 'd1) begin
            n_errors++;
            $display("FAIL restart: err=%0d level=%0d required err=%0d level=1",
                     err_count, fifo_level, m_err);
        end
        drain();
        n_checks++;
        if (got_q.size() != 1 || got_q[0] !== m_q[0]) begin
            n_errors++;
            $display("FAIL restart_data: frames=%0d head=%h required 1 frame %h",
                     got_q.size(), (got_q.size() > 0) ? got_q[0] : '0, m_q[0]);
        end
        m_q.delete();
    endtask

    task automatic test_coincident();
        logic [63:0] d = {$urandom, $urandom};
        strobe_strt();
        send_bits({$urandom, $urandom}, 10);
        dkstrt = 1'b1; dkend = 1'b1;
        hold(4);
        dkstrt = 1'b0; dkend = 1'b0;
        hold(4);
        if (m_err < 255) m_err++;
        n_checks++;
        if (busy !== 1'b1 || err_count !== 8'(m_err)) begin
            n_errors++;
            $display("FAIL coincident_restart: busy=%b err=%0d required busy=1 err=%0d",
                     busy, err_count, m_err);
        end
        send_bits(d, BITS);
        strobe_end();
        hold(2);
        model_frame(d, BITS);
        drain();
        n_checks++;
        if (got_q.size() != 1 || got_q[0] !== d[BITS-1:0]) begin
            n_errors++;
            $display("FAIL coincident_frame: frames=%0d required 1 frame %h", got_q.size(), d[BITS-1:0]);
        end
        m_q.delete();
    endtask

    task automatic test_parity();
        logic [63:0] d = {24'h0, 16'h0001, 16'h0003, 8'h5A};
        send_frame(d, BITS);
        drain();
        n_checks++;
        if (got_perr_q.size() != 1 || got_perr_q[0] !== exp_perr(d[39:0])) begin
            n_errors++;
            $display("FAIL parity: frames=%0d perr=%b required %b", got_perr_q.size(),
                     (got_perr_q.size() > 0) ? got_perr_q[0] : 2'bxx, exp_perr(d[39:0]));
        end
        m_q.delete();
    endtask

    task automatic test_random();
        for (int f = 0; f < 8; f++) begin
            int n = ($urandom_range(0, 2) == 0) ? int'($urandom_range(30, 48)) : BITS;
            send_frame({$urandom, $urandom}, n);
        end
        n_checks++;
        if (err_count !== 8'(m_err) || drop_count !== 8'(m_drop) ||
            fifo_level !== ($clog2(DEPTH)+1)'(m_q.size())) begin
            n_errors++;
            $display("FAIL random_counts: err=%0d drop=%0d level=%0d required %0d/%0d/%0d",
                     err_count, drop_count, fifo_level, m_err, m_drop, m_q.size());
        end
        drain();
        n_checks++;
        if (got_q.size() != m_q.size()) begin
            n_errors++;
            $display("FAIL random_drain: popped=%0d required %0d", got_q.size(), m_q.size());
        end
        for (int i = 0; i < m_q.size() && i < got_q.size(); i++) begin
            n_checks++;
            if (got_q[i] !== m_q[i] || got_perr_q[i] !== exp_perr(m_q[i])) begin
                n_errors++;
                $display("FAIL random_frame[%0d]: got %h/%b required %h/%b",
                         i, got_q[i], got_perr_q[i], m_q[i], exp_perr(m_q[i]));
            end
        end
        m_q.delete();
    endtask

    task automatic test_mid_reset();
        send_frame({$urandom, $urandom}, BITS);
        strobe_strt();
        send_bits({$urandom, $urandom}, 20);
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (u_if.frame_valid !== 1'b0 || fifo_level !== '0 || busy !== 1'b0 ||
            err_count !== 8'd0 || drop_count !== 8'd0 || u_if.frame_data !== '0) begin
            n_errors++;
            $display("FAIL mid_reset: valid=%b level=%0d busy=%b err=%0d drop=%0d data=%h required all 0",
                     u_if.frame_valid, fifo_level, busy, err_count, drop_count, u_if.frame_data);
        end
        m_q.delete();
        m_err = 0;
        m_drop = 0;
        hold(3);
        rst_n = 1'b1;
        hold(3);
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_nominal();
        test_short();
        test_long();
        test_backpressure();
        test_restart();
        test_coincident();
        test_parity();
        test_random();
        test_mid_reset();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/dk_downlink_capture.md
Name: dk_downlink_capture

Overview:
- Consumes the AGC digital downlink (DKSTRT, DKBSNC, DKEND, DKDATA) produced by the AGC core and paced by the PCM timing generator.
- Synchronises the strobes into the clk domain and shifts DKDATA into one frame per DKSTRT..DKEND sequence.
- Validates bit count and buffers completed frames in a small FIFO.
- Presents frames on a valid/ready interface to the monitor/UART path for host telemetry.

Parameters:
- BITS, 40, data bits per downlink frame; one DKBSNC pulse per bit.
- DEPTH, 4, frame FIFO depth; power of two, minimum 2.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous, active-low
- dkstrt  in  1  frame start strobe, asynchronous to clk
- dkbsnc  in  1  bit sync strobe, asynchronous
- dkend  in  1  frame end strobe, asynchronous
- dkdata  in  1  serial downlink data, asynchronous, stable while dkbsnc is high
- frame_data  out  BITS  head-of-FIFO frame; first received bit at MSB
- frame_valid  out  1  FIFO non-empty
- frame_ready  in  1  consumer accepts frame_data when frame_valid & frame_ready
- frame_perr  out  2  parity error flags for the head frame (see Optional Feature)
- fifo_level  out  $clog2(DEPTH)+1  frames currently buffered
- busy  out  1  frame assembly in progress
- drop_count  out  8  frames dropped on FIFO full; saturates at 255
- err_count  out  8  malformed frames; saturates at 255

Behaviour:
- Synchronisation
  - All four inputs pass through 2-flop synchronisers.
  - Rising-edge detect on synchronised dkstrt and dkend; falling-edge detect on synchronised dkbsnc.
  - dkdata is sampled from its synchronised copy on the same cycle the dkbsnc falling edge is detected.
  - Inputs must hold each high and low level for at least 3 clk cycles; shorter pulses are unsupported.
- Reset values: all outputs 0; FSM in IDLE; shift register, bit counter, FIFO pointers and both counters cleared.
- FSM states: IDLE, SHIFT, OVER.
  - IDLE
    - dkstrt edge -> SHIFT; clear shift register and bit counter.
    - dkbsnc and dkend edges are ignored.
  - SHIFT
    - Each dkbsnc falling edge: shift_reg <= {shift_reg[BITS-2:0], sample}; bit counter +1.
    - When a shift would make the count exceed BITS -> OVER; that bit is discarded.
    - dkend edge with count == BITS: push shift_reg into the FIFO, then -> IDLE.
    - dkend edge with count != BITS: err_count +1, no push, -> IDLE.
    - dkstrt edge mid-frame: err_count +1, restart assembly (clear register and counter), stay in SHIFT.
  - OVER
    - dkbsnc edges are ignored.
    - dkend edge: err_count +1, -> IDLE.
    - dkstrt edge: err_count +1, -> SHIFT, cleared.
- Simultaneous events in one cycle, by priority: dkstrt > dkend > dkbsnc.
- busy = (state != IDLE).
- Push latency: frame_valid rises 1 cycle after the cycle the dkend edge is detected. That is 4 clk cycles after dkend rises at the synchroniser input (2 sync + 1 edge + 1 write).
- FIFO
  - Push on full: frame discarded, drop_count +1, existing contents unchanged.
  - Pop on frame_valid & frame_ready.
  - Push and pop in the same cycle when full: the pop is performed first, the push succeeds, and there is no drop.
  - fifo_level is exact every cycle.
  - frame_data and frame_perr hold stable while frame_valid is high and frame_ready is low.
- Counters saturate at 255 and clear only on reset.
- Reset asserted mid-frame: the frame is lost, the FIFO is emptied, and all outputs return to reset values asynchronously.

Optional Feature:
- Macro: DK_PARITY_CHECK_EN
  - Requires BITS == 40.
  - On push, compute odd parity over frame bits [39:24] (word 1) and [23:8] (word 2).
  - frame_perr[1] / frame_perr[0] = 1 when word 1 / word 2 fails odd parity.
  - Flags are stored in the FIFO alongside the frame.
- Without the macro: frame_perr is tied to 2'b00 and no parity storage is instantiated.

Test Plan:
- Nominal frame: strobe dkstrt, then 40 dkbsnc pulses with data 0xA5A5_F00F_3C, then dkend.
  - Required: frame_valid rises 4 clk after the dkend edge; frame_data = 40'hA5A5F00F3C; err_count = 0; busy falls.
- Short frame: dkstrt, 39 bits, dkend.
  - Required: no push; err_count = 1; frame_valid stays 0.
- Long frame: dkstrt, 45 bits, dkend.
  - Required: FSM enters OVER after bit 40; err_count = 1; no push.
- Backpressure and drop: hold frame_ready = 0 while sending 6 valid frames.
  - Required: fifo_level = 4 and drop_count = 2.
  - Then assert frame_ready: the first 4 frames are popped in order and fifo_level returns to 0.
- Mid-frame restart plus simultaneous strobes.
  - dkstrt after 20 bits, then a full 40-bit frame. Required: err_count = 1; exactly one frame pushed.
  - dkstrt and dkend coincident. Required: restart wins.
  - Reset asserted mid-frame. Required: all outputs 0 immediately.
- With DK_PARITY_CHECK_EN: word 1 = 0x0001 (odd), word 2 = 0x0003 (even).
  - Required: frame_perr = 2'b01.
  - Without the macro, the same frame gives frame_perr = 2'b00.
